// File: rtl/m16_pkg.sv
// m16_pkg: shared widths and reset value for the modulo-16 one-hot counter
package m16_pkg;
  localparam int CNT_W = 4;
  localparam int OUT_W = 16;
  localparam logic [CNT_W-1:0] CNT_RESET = 4'd0;
endpackage

// File: rtl/m16_counter.sv
// m16_counter: 4-bit up/down counter with clear > load > count priority
module m16_counter
  import m16_pkg::*;
(
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             pe_i,
  input  logic             up_i,
  input  logic [CNT_W-1:0] d_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // next count: clear wins, then load, then count in the selected direction, else hold
  always_comb begin
    cnt_d = clr_i ? CNT_RESET :
            pe_i  ? d_i :
            en_i  ? (up_i ? cnt_q + 4'd1 : cnt_q - 4'd1) :
                    cnt_q;
  end
  // count register; the clear is folded into cnt_d so it stays synchronous
  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/m16_updown_onehot_counter.sv
// m16_updown_onehot_counter: modulo-16 up/down counter driving a 16-line one-hot bank
module m16_updown_onehot_counter
  import m16_pkg::*;
(
  input  logic             CP,
  input  logic             CLR,
  input  logic             EN_0,
  input  logic             PE,
  input  logic             flag,
  input  logic [CNT_W-1:0] D,
  output logic [OUT_W-1:0] Q
);
  logic [CNT_W-1:0] cnt;
  function automatic logic [OUT_W-1:0] onehot(input logic [CNT_W-1:0] c);
    onehot = OUT_W'(1) << c;
  endfunction
  m16_counter u_counter (
    .clk_i (CP),
    .clr_i (CLR),
    .en_i  (EN_0),
    .pe_i  (PE),
    .up_i  (flag),
    .d_i   (D),
    .cnt_o (cnt)
  );
  // one output line per counter state, decoded from the registered count
  always_comb begin
    Q = onehot(cnt);
  end
endmodule

// File: tb/tb_m16_updown_onehot_counter.sv
// tb_m16_updown_onehot_counter: directed and randomized checks against a behavioural count model
module tb_m16_updown_onehot_counter;
  logic        CP = 1'b0;
  logic        CLR = 1'b0;
  logic        EN_0 = 1'b0;
  logic        PE = 1'b0;
  logic        flag = 1'b0;
  logic [3:0]  D = 4'd0;
  logic [15:0] Q;
  int model = 0;
  int checks = 0;
  int fails = 0;

  m16_updown_onehot_counter dut (
    .CP   (CP),
    .CLR  (CLR),
    .EN_0 (EN_0),
    .PE   (PE),
    .flag (flag),
    .D    (D),
    .Q    (Q)
  );

  always #5 CP = ~CP;

  function automatic logic [15:0] exp_q(input int n);
    logic [15:0] r;
    r = '0;
    r[n] = 1'b1;
    return r;
  endfunction

  task automatic drive(input logic clr, input logic pe, input logic en, input logic fl, input logic [3:0] d);
    @(negedge CP);
    CLR = clr;
    PE = pe;
    EN_0 = en;
    flag = fl;
    D = d;
    @(posedge CP);
    if (clr) model = 0;
    else if (pe) model = int'(d);
    else if (en) model = fl ? (model + 1) % 16 : (model + 15) % 16;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
    checks++;
    if (Q !== 16'h0001) begin
      fails++;
      $display("FAIL reset: Q=%h expected %h", Q, 16'h0001);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'($urandom), 4'($urandom));
      checks++;
      if (Q !== 16'h0001) begin
        fails++;
        $display("FAIL reset_hold %0d: Q=%h expected %h", i, Q, 16'h0001);
      end
    end
  endtask

  task automatic test_count_up();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 4'($urandom));
      checks++;
      if (Q !== exp_q(i % 16)) begin
        fails++;
        $display("FAIL count_up step %0d: Q=%h expected %h", i, Q, exp_q(i % 16));
      end
    end
  endtask

  task automatic test_count_down();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    checks++;
    if (Q !== 16'h8000) begin
      fails++;
      $display("FAIL count_down wrap: Q=%h expected %h", Q, 16'h8000);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    checks++;
    if (Q !== 16'h4000) begin
      fails++;
      $display("FAIL count_down next: Q=%h expected %h", Q, 16'h4000);
    end
  endtask

  task automatic test_load();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'b1001);
    checks++;
    if (Q !== 16'h0200) begin
      fails++;
      $display("FAIL load: Q=%h expected %h", Q, 16'h0200);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd3);
    checks++;
    if (Q !== 16'h0400) begin
      fails++;
      $display("FAIL load_then_up: Q=%h expected %h", Q, 16'h0400);
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd6);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'($urandom), 4'($urandom));
      checks++;
      if (Q !== 16'h0040) begin
        fails++;
        $display("FAIL hold %0d: Q=%h expected %h", i, Q, 16'h0040);
      end
    end
  endtask

  task automatic test_priority();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd9);
    checks++;
    if (Q !== 16'h0001) begin
      fails++;
      $display("FAIL clr_over_load: Q=%h expected %h", Q, 16'h0001);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd9);
    checks++;
    if (Q !== 16'h0200) begin
      fails++;
      $display("FAIL load_over_count: Q=%h expected %h", Q, 16'h0200);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom));
      checks++;
      if (Q !== exp_q(model)) begin
        fails++;
        $display("FAIL random %0d: Q=%h expected %h", i, Q, exp_q(model));
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_hold();
    test_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
